ysyx_axi_sram: RTL and testbench

YSYX_AXI_SRAM -- requirements
Module: ysyx_axi_sram

---
 rtl/ysyx_axi_sram_if.sv | 34 +++
 rtl/ysyx_axi_sram.sv | 145 ++++++++++++++
 tb/tb_ysyx_axi_sram.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_axi_sram_if.sv
// AXI-style bus bundle for ysyx_axi_sram: AR/R read channels and AW/W/B write channels.
// The slave modport is the SRAM side; the master modport is the requester side.
interface ysyx_axi_sram_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready_o;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready;

  modport slave (
    input  araddr, arlen, arvalid, rready, awaddr, awlen, awvalid, wdata, wstrb, wvalid, bready,
    output arready_o, rdata_o, rresp_o, rlast_o, rvalid_o, awready_o, wready_o, bresp_o, bvalid_o
  );

  modport master (
    output araddr, arlen, arvalid, rready, awaddr, awlen, awvalid, wdata, wstrb, wvalid, bready,
    input  arready_o, rdata_o, rresp_o, rlast_o, rvalid_o, awready_o, wready_o, bresp_o, bvalid_o
  );
endinterface

// File: rtl/ysyx_axi_sram.sv
// 64-bit burst SRAM slave with independent read and write FSMs and per-beat range decode.
// Define YSYX_AXI_SRAM_DELAY_EN to add LFSR-driven ready/latency jitter.
module ysyx_axi_sram #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024
) (
  input  logic           clk,
  input  logic           rst,
  ysyx_axi_sram_if.slave bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [32:0] TOP = {1'b0, BASE} + 33'(DEPTH) * 33'd8;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t    r_state;
  w_state_t    w_state;
  logic [31:0] r_addr, w_addr, r_next;
  logic [7:0]  r_len, r_cnt, w_len, w_cnt;
  logic        w_err, go, ar_fire, aw_fire, w_fire;
  logic [63:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < TOP);
  endfunction

  function automatic logic [AW-1:0] idx_of(input logic [31:0] a);
    return AW'((a - BASE) >> 3);
  endfunction

  function automatic logic [63:0] rd_word(input logic [31:0] a);
    return in_range(a) ? mem[idx_of(a)] : 64'd0;
  endfunction

`ifdef YSYX_AXI_SRAM_DELAY_EN
  logic [19:0] lfsr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 20'd1;
    else      lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[18]};
  end
  assign go = lfsr[19];
`else
  assign go = 1'b1;
`endif

  assign bus.arready_o = (r_state == R_IDLE) && go;
  assign bus.awready_o = (w_state == W_IDLE) && go;
  assign bus.wready_o  = (w_state == W_DATA) && go;
  assign ar_fire = bus.arvalid && bus.arready_o;
  assign aw_fire = bus.awvalid && bus.awready_o;
  assign w_fire  = bus.wvalid && bus.wready_o;
  assign r_next  = r_addr + 32'd8;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= R_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      bus.rvalid_o <= 1'b0;
      bus.rlast_o  <= 1'b0;
      bus.rdata_o  <= '0;
      bus.rresp_o  <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (ar_fire) begin
          r_addr  <= bus.araddr;
          r_len   <= bus.arlen;
          r_cnt   <= '0;
          r_state <= R_WAIT;
        end
        R_WAIT: if (go) begin
          r_state      <= R_DATA;
          bus.rvalid_o <= 1'b1;
          bus.rdata_o  <= rd_word(r_addr);
          bus.rresp_o  <= in_range(r_addr) ? 2'b00 : 2'b11;
          bus.rlast_o  <= (r_len == 8'd0);
        end
        R_DATA: if (bus.rready) begin
          if (r_cnt == r_len) begin
            r_state      <= R_IDLE;
            bus.rvalid_o <= 1'b0;
            bus.rlast_o  <= 1'b0;
          end else begin
            // Next beat is fetched on the accepting edge, so it sees pre-write memory.
            r_addr      <= r_next;
            r_cnt       <= r_cnt + 8'd1;
            bus.rdata_o <= rd_word(r_next);
            bus.rresp_o <= in_range(r_next) ? 2'b00 : 2'b11;
            bus.rlast_o <= ((r_cnt + 8'd1) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state      <= W_IDLE;
      w_addr       <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_err        <= 1'b0;
      bus.bvalid_o <= 1'b0;
      bus.bresp_o  <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: if (aw_fire) begin
          w_addr  <= bus.awaddr;
          w_len   <= bus.awlen;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          w_addr <= w_addr + 32'd8;
          w_err  <= w_err || !in_range(w_addr);
          if (w_cnt == w_len) begin
            w_state      <= W_RESP;
            bus.bvalid_o <= 1'b1;
            bus.bresp_o  <= (w_err || !in_range(w_addr)) ? 2'b11 : 2'b00;
          end else begin
            w_cnt <= w_cnt + 8'd1;
          end
        end
        W_RESP: if (bus.bready) begin
          w_state      <= W_IDLE;
          bus.bvalid_o <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_fire && in_range(w_addr)) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wstrb[b]) mem[idx_of(w_addr)][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_axi_sram.sv
// Randomized self-checking bench for ysyx_axi_sram against a word-array reference model.
module tb_ysyx_axi_sram;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;
  localparam int          TMO   = 200;
`ifdef YSYX_AXI_SRAM_DELAY_EN
  localparam int N_BURST = 500;
`else
  localparam int N_BURST = 300;
`endif

  logic clk, rst;
  ysyx_axi_sram_if bus ();

  ysyx_axi_sram #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] model [DEPTH];
  logic [63:0] wd_q [$];
  logic [7:0]  ws_q [$];
  bit          rdy_pat [$];
  logic [63:0] first_rdata;
  logic        seen_ar_low = 1'b0;

  always @(negedge clk) if (rst && !bus.arready_o) seen_ar_low = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_in(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 8 * DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 8);
  endfunction

  function automatic logic [63:0] exp_rd(input logic [31:0] a);
    return m_in(a) ? model[m_idx(a)] : 64'd0;
  endfunction

  function automatic logic [31:0] addr_of(input int idx);
    return BASE + 32'(idx * 8) + 32'($urandom_range(7));
  endfunction

  task automatic do_write(input logic [31:0] a, input int gap_pct);
    int          len, t, k;
    bit          err;
    logic [31:0] ba;
    logic [63:0] d [$];
    logic [7:0]  s [$];
    d = wd_q; s = ws_q;
    wd_q.delete(); ws_q.delete();
    len = d.size() - 1;
    err = 1'b0;
    @(negedge clk);
    bus.awaddr = a; bus.awlen = 8'(len); bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready_o && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin chk("aw_timeout", 0, 1); bus.awvalid = 1'b0; return; end
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      k = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
      repeat (k) @(negedge clk);
      bus.wvalid = 1'b1; bus.wdata = d[i]; bus.wstrb = s[i];
      t = 0;
      while (!bus.wready_o && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin chk("w_timeout", 0, 1); bus.wvalid = 1'b0; return; end
      @(negedge clk);
      bus.wvalid = 1'b0;
      ba = a + 32'(8 * i);
      if (m_in(ba)) begin
        for (int b = 0; b < 8; b++) if (s[i][b]) model[m_idx(ba)][8*b +: 8] = d[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
    end
    chk("bvalid_lat", bus.bvalid_o, 1);
    chk("bresp", bus.bresp_o, err ? 2'b11 : 2'b00);
    repeat ($urandom_range(2)) begin
      @(negedge clk);
      chk("bvalid_hold", bus.bvalid_o, 1);
      chk("bresp_hold", bus.bresp_o, err ? 2'b11 : 2'b00);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("bvalid_end", bus.bvalid_o, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input int stall_pct, input int abort_after);
    int          t, beat, hs;
    logic [31:0] ba;
    @(negedge clk);
    bus.araddr = a; bus.arlen = 8'(len); bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready_o && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin chk("ar_timeout", 0, 1); bus.arvalid = 1'b0; return; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rvalid_wait", bus.rvalid_o, 0);
`ifndef YSYX_AXI_SRAM_DELAY_EN
    @(negedge clk);
    chk("rvalid_lat", bus.rvalid_o, 1);
`endif
    beat = 0; hs = 0;
    while (beat <= len) begin
      t = 0;
      while (!bus.rvalid_o && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin chk("r_timeout", 0, 1); return; end
      ba = a + 32'(8 * beat);
      if (beat == 0) first_rdata = bus.rdata_o;
      chk($sformatf("rdata[%0d]", beat), bus.rdata_o, exp_rd(ba));
      chk($sformatf("rresp[%0d]", beat), bus.rresp_o, m_in(ba) ? 2'b00 : 2'b11);
      chk($sformatf("rlast[%0d]", beat), bus.rlast_o, (beat == len));
      if (hs == abort_after) return;
      if (rdy_pat.size() > 0) bus.rready = rdy_pat.pop_front();
      else                    bus.rready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (bus.rready) begin beat++; hs++; end
      bus.rready = 1'b0;
    end
    chk("rvalid_end", bus.rvalid_o, 0);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      wd_q.push_back({$urandom, $urandom});
      ws_q.push_back(8'($urandom_range(255)));
    end
  endtask

  int kind, len, si, wi, ri;

  initial begin
    bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_rlast", bus.rlast_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_rresp", bus.rresp_o, 0);
    chk("rst_wready", bus.wready_o, 0);
    chk("rst_bvalid", bus.bvalid_o, 0);
    chk("rst_bresp", bus.bresp_o, 0);
`ifndef YSYX_AXI_SRAM_DELAY_EN
    chk("rst_arready", bus.arready_o, 1);
    chk("rst_awready", bus.awready_o, 1);
`endif
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      wd_q.push_back({$urandom, $urandom});
      ws_q.push_back(8'hFF);
    end
    do_write(BASE, 20);
    do_read(BASE, DEPTH - 1, 20, -1);

    wd_q.push_back(64'h1122334455667788); ws_q.push_back(8'hFF);
    do_write(32'h8000_0010, 0);
    do_read(32'h8000_0010, 0, 0, -1);
    chk("full_word", first_rdata, 64'h1122334455667788);

    wd_q.push_back(64'hAAAA_AAAA_AAAA_AAAA); ws_q.push_back(8'h0F);
    do_write(32'h8000_0010, 0);
    do_read(32'h8000_0010, 0, 0, -1);
    chk("low_half_strb", first_rdata, 64'h1122_3344_AAAA_AAAA);

    for (int i = 0; i < 4; i++) begin wd_q.push_back(64'(i)); ws_q.push_back(8'hFF); end
    do_write(BASE, 0);
    rdy_pat = '{1, 0, 1, 1, 1};
    do_read(BASE, 3, 0, -1);

    do_read(32'h7FFF_FFF8, 0, 0, -1);
    wd_q.push_back(64'hDEAD_BEEF_0BAD_F00D); ws_q.push_back(8'hFF);
    do_write(32'h9000_0000, 0);
    do_read(BASE, 0, 0, -1);
    chk("oor_no_alias", first_rdata, 64'd0);

    fill_rand(4);
    do_write(BASE + 32'(8 * (DEPTH - 2)), 10);
    do_read(BASE + 32'(8 * (DEPTH - 2)), 3, 10, -1);

    do_read(BASE, 7, 0, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.rvalid_o, 0);
    chk("mid_rst_rlast", bus.rlast_o, 0);
    chk("mid_rst_rdata", bus.rdata_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
`ifndef YSYX_AXI_SRAM_DELAY_EN
    chk("post_rst_arready", bus.arready_o, 1);
`endif
    do_read(32'h8000_0010, 1, 0, -1);

    for (int n = 0; n < N_BURST; n++) begin
      kind = $urandom_range(2);
      len  = $urandom_range(7);
      si   = $urandom_range(DEPTH + 5) - 3;
      case (kind)
        0: begin fill_rand(len + 1); do_write(addr_of(si), $urandom_range(40)); end
        1: do_read(addr_of(si), len, $urandom_range(50), -1);
        default: begin
          fill_rand(len + 1);
          wi = $urandom_range(DEPTH / 2 - 8);
          ri = DEPTH / 2 + $urandom_range(DEPTH / 2 + 2);
          fork
            do_write(addr_of(wi), 30);
            do_read(addr_of(ri), $urandom_range(7), 30, -1);
          join
        end
      endcase
    end

    chk("arready_low_seen", seen_ar_low, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
